instr_fetch_reg: RTL and testbench
==================================

# instr_fetch_reg

Instruction fetch and instruction register stage, directly upstream of the ALU. Reads one 16-bit instruction as two bytes from the 8-bit program memory, assembles it, and presents opcode[2:0] and operand address ir_addr[12:0] to the execute stage through a valid/ready handshake. Latches HLT and stops fetching until reset.

## Interface
- AW, 13, program/operand address width; instruction width is fixed at 3 + AW = 16
- DW, 8, memory data width
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- fetch_req  in  1  level; request fetch at address pc
- pc  in  AW  byte address of instruction high byte
- flush  in  1  abort fetch, drop held instruction
- mem_rd  out  1  memory read strobe
- mem_addr  out  AW  memory byte address
- mem_ack  in  1  one-cycle pulse; mem_data valid this cycle
- mem_data  in  DW  read data
- ir_valid  out  1  opcode/ir_addr hold a complete instruction
- ir_ready  in  1  execute stage accepts
- opcode  out  3  instruction bits [15:13]
- ir_addr  out  AW  instruction bits [12:0]
- pc_inc  out  1  one-cycle pulse on handshake: PC owner adds 2
- halted  out  1  HLT accepted; sticky until reset

## Operation
- States: IDLE, RD_HI, RD_LO, HOLD, HALT.
- IDLE: fetch_req=1 -> latch pc into addr_q, go RD_HI.
- RD_HI: mem_rd=1, mem_addr=addr_q. mem_ack -> capture mem_data into ir[15:8], go RD_LO.
- RD_LO: mem_rd=1, mem_addr=addr_q+1 (mod 2^AW, 0x1FFF+1 = 0x0000). mem_ack -> capture into ir[7:0], go HOLD.
- HOLD: ir_valid=1; opcode/ir_addr stable until transfer. ir_valid & ir_ready -> pc_inc pulse; if opcode==HLT go HALT, else if fetch_req=1 latch pc and go RD_HI, else IDLE.
- HALT: halted=1, mem_rd=0, ir_valid=0; fetch_req and flush ignored; only rst_n=0 exits.
- flush (any state except HALT): next state IDLE, ir_valid and mem_rd drop next cycle; flush beats mem_ack and the handshake in the same cycle (byte discarded, no pc_inc).
- mem_ack outside RD_HI/RD_LO: ignored.
- No wait limit: mem_rd held indefinitely until mem_ack.

## Timing
- Reset (rst_n=0 at edge): state IDLE; mem_rd, ir_valid, pc_inc, halted = 0; mem_addr, opcode, ir_addr = 0. Reset mid-fetch or in HALT fully aborts.
- mem_rd, mem_addr, ir_valid, halted, opcode, ir_addr are registered; pc_inc is registered and high exactly one cycle after the transfer edge.
- Minimum latency with zero-wait memory (mem_ack in the first cycle of each read): fetch_req sampled at edge 0 -> RD_HI cycle 1 -> RD_LO cycle 2 -> ir_valid high cycle 3.
- Back-to-back with ir_ready=1 and fetch_req held: one instruction every 3 cycles.
- opcode/ir_addr change only on entry to HOLD; values from the ALU stage never feed back.

## Structure
- Shared package cpu_pkg: opcode constants HLT=0, SKZ=1, ADD=2, ANDD=3, XORR=4, LDA=5, STO=6, JMP=7 (same values the ALU decodes), AW/DW defaults, fetch state enum.
- Single module; no sub-module. Byte assembly is a 16-bit register written by halves.

## Test plan
- Zero-wait fetch: pc=0x0010, mem returns 0xA5 then 0x3C -> mem_addr 0x0010 then 0x0011; ir_valid in cycle 3, opcode=5 (LDA), ir_addr=0x053C; pc_inc pulses once after ir_ready.
- Backpressure: ir_ready=0 for 5 cycles while in HOLD -> opcode/ir_addr/ir_valid stable, mem_rd=0, no pc_inc; release ir_ready -> single transfer.
- Wait states and wrap: pc=0x1FFF, mem_ack delayed 3 cycles per byte -> mem_rd held, second read address 0x0000, instruction assembled correctly.
- Flush same cycle as low-byte mem_ack -> IDLE next cycle, ir_valid never asserts, no pc_inc; next fetch_req refetches cleanly.
- HLT: fetch 0x0000 and accept -> halted=1, fetch_req=1 ignored for 20 cycles; rst_n=0 for one edge -> halted=0, IDLE.
- Reset during RD_LO -> all outputs 0 next cycle; no stale ir_valid.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding (same values the ALU decodes),
// default bus widths and the instruction fetch state encoding.
package cpu_pkg;

  localparam int unsigned AW_DEF = 13;  // program/operand address width
  localparam int unsigned DW_DEF = 8;   // program memory data width
  localparam int unsigned OPW    = 3;   // opcode field width

  // Instruction opcodes
  typedef enum logic [OPW-1:0] {
    OP_HLT  = 3'd0,
    OP_SKZ  = 3'd1,
    OP_ADD  = 3'd2,
    OP_ANDD = 3'd3,
    OP_XORR = 3'd4,
    OP_LDA  = 3'd5,
    OP_STO  = 3'd6,
    OP_JMP  = 3'd7
  } opcode_e;

  // Fetch stage states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_HI = 3'd1,
    ST_RD_LO = 3'd2,
    ST_HOLD  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // True when the opcode field stops the machine
  function automatic logic is_halt(input logic [OPW-1:0] op);
    return op == OP_HLT;
  endfunction

endpackage : cpu_pkg

// File: rtl/instr_fetch_reg.sv
// Instruction fetch / instruction register stage.
// Reads a (3+AW)-bit instruction as two DW-bit bytes (high byte at pc,
// low byte at pc+1), then offers opcode/ir_addr to the execute stage on a
// valid/ready handshake. An accepted HLT parks the stage until reset.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   fetch_req, pc    level fetch request and instruction byte address
//   flush            abort any fetch and drop a held instruction
//   mem_rd, mem_addr registered memory read strobe / byte address
//   mem_ack,mem_data one-cycle read acknowledge with data
//   ir_valid,ir_ready instruction handshake to execute stage
//   opcode, ir_addr  instruction fields [15:13] / [12:0]
//   pc_inc           one-cycle pulse after each transfer
//   halted           sticky HLT indication
module instr_fetch_reg
  import cpu_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic [AW-1:0] pc,
  input  logic          flush,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [OPW-1:0] opcode,
  output logic [AW-1:0] ir_addr,
  output logic          pc_inc,
  output logic          halted
);

  localparam int unsigned IW = OPW + AW;  // instruction width, two bytes

  fetch_state_e  state;
  logic [AW-1:0] addr_q;   // address of the instruction high byte
  logic [DW-1:0] hi_q;     // high byte staged until the low byte lands
  logic [IW-1:0] ir_q;     // instruction register, loaded on HOLD entry

  // Fields come straight from the instruction register so they only move
  // when a complete instruction is loaded.
  assign opcode  = ir_q[IW-1 -: OPW];
  assign ir_addr = ir_q[AW-1:0];

  // Single-process FSM; all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      hi_q     <= '0;
      ir_q     <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      ir_valid <= 1'b0;
      pc_inc   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      pc_inc <= 1'b0;

      // Flush outranks memory acknowledge and handshake; HALT is deaf to it.
      if (flush && (state != ST_HALT)) begin
        state    <= ST_IDLE;
        mem_rd   <= 1'b0;
        ir_valid <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (fetch_req) begin
              addr_q   <= pc;
              mem_rd   <= 1'b1;
              mem_addr <= pc;
              state    <= ST_RD_HI;
            end
          end

          ST_RD_HI: begin
            // Read strobe stays up with no timeout until the memory answers.
            if (mem_ack) begin
              hi_q     <= mem_data;
              mem_addr <= addr_q + AW'(1);  // wraps at the top of memory
              state    <= ST_RD_LO;
            end
          end

          ST_RD_LO: begin
            if (mem_ack) begin
              ir_q     <= IW'({hi_q, mem_data});
              mem_rd   <= 1'b0;
              ir_valid <= 1'b1;
              state    <= ST_HOLD;
            end
          end

          ST_HOLD: begin
            if (ir_ready) begin
              pc_inc   <= 1'b1;
              ir_valid <= 1'b0;
              if (is_halt(opcode)) begin
                halted <= 1'b1;
                state  <= ST_HALT;
              end else if (fetch_req) begin
                // Chain straight into the next fetch: 3 cycles per instruction.
                addr_q   <= pc;
                mem_rd   <= 1'b1;
                mem_addr <= pc;
                state    <= ST_RD_HI;
              end else begin
                state <= ST_IDLE;
              end
            end
          end

          ST_HALT: begin
            // Only reset leaves this state.
            mem_rd   <= 1'b0;
            ir_valid <= 1'b0;
          end

          default: begin
            state    <= ST_IDLE;
            mem_rd   <= 1'b0;
            ir_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : instr_fetch_reg

// File: tb/tb_instr_fetch_reg.sv
// Directed bench for instr_fetch_reg. The bench plays program memory;
// expected instructions are queued when their bytes are driven and
// compared when the stage offers them on the handshake.
module tb_instr_fetch_reg;
  import cpu_pkg::*;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] pc;
  logic          flush;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic          ir_valid;
  logic          ir_ready;
  logic [2:0]    opcode;
  logic [AW-1:0] ir_addr;
  logic          pc_inc;
  logic          halted;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  instr_fetch_reg #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_req(fetch_req),
    .pc       (pc),
    .flush    (flush),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .opcode   (opcode),
    .ir_addr  (ir_addr),
    .pc_inc   (pc_inc),
    .halted   (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a read strobe, check its address, optionally stall,
  // then return one byte with a single-cycle acknowledge.
  task automatic serve(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int waits);
    for (int i = 0; i < 50 && mem_rd !== 1'b1; i++) step();
    chk("mem_rd_seen", 32'(mem_rd), 32'd1);
    chk("mem_addr", 32'(mem_addr), 32'(addr));
    for (int i = 0; i < waits; i++) begin
      step();
      chk("mem_rd_held", 32'(mem_rd), 32'd1);
      chk("mem_addr_held", 32'(mem_addr), 32'(addr));
    end
    mem_ack  = 1'b1;
    mem_data = data;
    step();
    mem_ack  = 1'b0;
  endtask

  // Compare the held instruction against the scoreboard, then transfer it.
  task automatic accept();
    logic [15:0] exp;
    chk("ir_valid_hold", 32'(ir_valid), 32'd1);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    exp = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
    chk("opcode", 32'(opcode), 32'(exp[15:13]));
    chk("ir_addr", 32'(ir_addr), 32'(exp[12:0]));
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    chk("pc_inc_pulse", 32'(pc_inc), 32'd1);
    chk("ir_valid_drop", 32'(ir_valid), 32'd0);
    step();
    chk("pc_inc_single", 32'(pc_inc), 32'd0);
  endtask

  task automatic start_fetch(input logic [AW-1:0] addr);
    fetch_req = 1'b1;
    pc        = addr;
    step();
    fetch_req = 1'b0;
  endtask

  initial begin
    logic [2:0]    op_snap;
    logic [AW-1:0] ad_snap;
    rst_n = 1'b0; fetch_req = 1'b0; pc = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_data = '0; ir_ready = 1'b0;
    step(); step();
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_pc_inc", 32'(pc_inc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_ir_addr", 32'(ir_addr), 32'd0);
    rst_n = 1'b1;
    step();

    // Stray acknowledge while idle must be ignored
    mem_ack = 1'b1; mem_data = 8'hFF;
    step();
    mem_ack = 1'b0;
    step();
    chk("idle_ack_ignored", 32'(ir_valid), 32'd0);
    chk("idle_no_rd", 32'(mem_rd), 32'd0);

    // Zero-wait fetch with exact cycle latency
    start_fetch(13'h0010);
    chk("zw_rd_c1", 32'(mem_rd), 32'd1);
    chk("zw_addr_c1", 32'(mem_addr), 32'h0010);
    mem_ack = 1'b1; mem_data = 8'hA5;
    step();
    chk("zw_rd_c2", 32'(mem_rd), 32'd1);
    chk("zw_addr_c2", 32'(mem_addr), 32'h0011);
    mem_data = 8'h3C;
    sb.push_back(16'hA53C);
    step();
    mem_ack = 1'b0;
    chk("zw_valid_c3", 32'(ir_valid), 32'd1);
    chk("zw_rd_off_c3", 32'(mem_rd), 32'd0);
    chk("zw_opcode_lda", 32'(opcode), 32'(OP_LDA));
    accept();

    // Backpressure: hold five cycles, then one transfer
    start_fetch(13'h0100);
    serve(13'h0100, 8'h4F, 0);
    sb.push_back(16'h4F01);
    serve(13'h0101, 8'h01, 0);
    op_snap = 3'd2; ad_snap = 13'h0F01;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(ir_valid), 32'd1);
      chk("bp_opcode", 32'(opcode), 32'(op_snap));
      chk("bp_ir_addr", 32'(ir_addr), 32'(ad_snap));
      chk("bp_no_rd", 32'(mem_rd), 32'd0);
      chk("bp_no_pc_inc", 32'(pc_inc), 32'd0);
    end
    accept();

    // Wait states and address wrap
    start_fetch(13'h1FFF);
    serve(13'h1FFF, 8'hE0, 3);
    sb.push_back(16'hE007);
    serve(13'h0000, 8'h07, 3);
    accept();

    // Flush beats the low-byte acknowledge
    start_fetch(13'h0200);
    serve(13'h0200, 8'h55, 0);
    chk("fl_rd_lo_addr", 32'(mem_addr), 32'h0201);
    mem_ack = 1'b1; mem_data = 8'h66; flush = 1'b1;
    step();
    mem_ack = 1'b0; flush = 1'b0;
    chk("fl_rd_drop", 32'(mem_rd), 32'd0);
    chk("fl_valid_low", 32'(ir_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_valid", 32'(ir_valid), 32'd0);
      chk("fl_no_pc_inc", 32'(pc_inc), 32'd0);
    end
    start_fetch(13'h0200);
    serve(13'h0200, 8'h55, 0);
    sb.push_back(16'h5566);
    serve(13'h0201, 8'h66, 0);
    accept();

    // Reset while reading the low byte
    start_fetch(13'h0300);
    serve(13'h0300, 8'hC1, 0);
    chk("rl_in_rd_lo", 32'(mem_rd), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rl_mem_rd", 32'(mem_rd), 32'd0);
    chk("rl_mem_addr", 32'(mem_addr), 32'd0);
    chk("rl_ir_valid", 32'(ir_valid), 32'd0);
    chk("rl_opcode", 32'(opcode), 32'd0);
    chk("rl_ir_addr", 32'(ir_addr), 32'd0);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_data = 8'h22;
    step();
    mem_ack = 1'b0;
    step();
    chk("rl_no_stale_valid", 32'(ir_valid), 32'd0);

    // HLT: accepted with fetch_req held, then sticky until reset
    start_fetch(13'h0000);
    serve(13'h0000, 8'h12, 0);
    sb.push_back(16'h1234);
    serve(13'h0001, 8'h34, 0);
    fetch_req = 1'b1;
    accept();
    for (int i = 0; i < 20; i++) begin
      flush = (i >= 10);
      chk("hlt_halted", 32'(halted), 32'd1);
      chk("hlt_no_rd", 32'(mem_rd), 32'd0);
      chk("hlt_no_valid", 32'(ir_valid), 32'd0);
      step();
    end
    flush = 1'b0; fetch_req = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("hlt_rst_halted", 32'(halted), 32'd0);
    step();
    chk("hlt_rst_idle", 32'(mem_rd), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_fetch_reg
